// File: rtl/branch_resolve_queue_pkg.sv
// Shared branch-prediction constants and types: queue depth, address/counter widths,
// predictor table sizes, and the in-flight prediction record.
package branch_resolve_queue_pkg;

  localparam int unsigned BRQ_DEPTH   = 4;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned STAT_CNT_W  = 16;
  localparam int unsigned BHT_ENTRIES = 512;
  localparam int unsigned BTB_ENTRIES = 64;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    addr_t pc;
    addr_t target;
    logic  prediction;
  } brq_entry_t;

  // Fall-through fetch address; wraps at 2^32.
  function automatic addr_t next_seq_pc(input addr_t pc);
    return pc + addr_t'(4);
  endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Decode/resolve/update bundle between the pipeline (master) and the resolve queue (slave).
interface branch_resolve_queue_if
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned CNT_W = STAT_CNT_W
) ();

  logic             dec_valid;
  addr_t            dec_pc;
  addr_t            dec_target;
  logic             dec_prediction;
  logic             res_valid;
  logic             res_taken;
  addr_t            res_target;
  logic             full;
  logic             empty;
  logic             mispredict;
  addr_t            redirect_pc;
  logic             upd_valid;
  addr_t            upd_addr;
  logic             upd_taken;
  logic             overflow;
  logic             underflow;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output dec_valid, dec_pc, dec_target, dec_prediction,
    output res_valid, res_taken, res_target,
    input  full, empty, mispredict, redirect_pc, upd_valid, upd_addr, upd_taken,
    input  overflow, underflow, branch_count, mispredict_count
  );

  modport slave (
    input  dec_valid, dec_pc, dec_target, dec_prediction,
    input  res_valid, res_taken, res_target,
    output full, empty, mispredict, redirect_pc, upd_valid, upd_addr, upd_taken,
    output overflow, underflow, branch_count, mispredict_count
  );

endinterface

// File: rtl/branch_resolve_queue_bp_fifo.sv
// Circular FIFO of in-flight predictions; pointers wrap modulo DEPTH (power of two).
// Flush empties the queue while still honouring a same-cycle pop; a push on flush is dropped.
module bp_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = BRQ_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  brq_entry_t push_dat_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic       full_o,
  output logic       empty_o,
  output brq_entry_t head_dat_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  brq_entry_t       mem_q [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign head_dat_o = mem_q[head_q];

  // A pop frees the slot the push needs, so a full queue still accepts push+pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_pop) begin
      head_d = head_q + 1'b1;
    end
    if (flush_i) begin
      tail_d  = head_d;
      count_d = '0;
    end else begin
      if (do_push) begin
        tail_d = tail_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem_q[tail_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks in-flight branch predictions, checks them at resolve, and emits registered
// redirect/predictor-update pulses one cycle after each resolve.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = BRQ_DEPTH,
  parameter int unsigned CNT_W = STAT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_queue_if.slave brq
);

  brq_entry_t       push_dat;
  brq_entry_t       head_dat;
  logic             fifo_full;
  logic             fifo_empty;
  logic             res_ok;
  logic             mis_now;

  logic             mispredict_q, mispredict_d;
  logic             upd_valid_q, upd_valid_d;
  addr_t            redirect_pc_q, redirect_pc_d;
  addr_t            upd_addr_q, upd_addr_d;
  logic             upd_taken_q, upd_taken_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  assign push_dat = '{pc: brq.dec_pc, target: brq.dec_target, prediction: brq.dec_prediction};

  assign res_ok  = brq.res_valid && !fifo_empty;
  // Target only matters when the branch was actually taken.
  assign mis_now = res_ok && ((head_dat.prediction != brq.res_taken) ||
                              (brq.res_taken && (head_dat.target != brq.res_target)));

  bp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (brq.dec_valid),
    .push_dat_i (push_dat),
    .pop_i      (brq.res_valid),
    .flush_i    (mis_now),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_dat_o (head_dat)
  );

  always_comb begin
    mispredict_d       = mis_now;
    upd_valid_d        = res_ok;
    redirect_pc_d      = redirect_pc_q;
    upd_addr_d         = upd_addr_q;
    upd_taken_d        = upd_taken_q;
    overflow_d         = overflow_q;
    underflow_d        = underflow_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (res_ok) begin
      redirect_pc_d = brq.res_taken ? brq.res_target : next_seq_pc(head_dat.pc);
      upd_addr_d    = head_dat.pc;
      upd_taken_d   = brq.res_taken;
      if (branch_count_q != '1) begin
        branch_count_d = branch_count_q + 1'b1;
      end
    end
    if (mis_now && (mispredict_count_q != '1)) begin
      mispredict_count_d = mispredict_count_q + 1'b1;
    end
    // Full with a resolve in the same cycle is not an overflow: the pop makes room.
    if (brq.dec_valid && fifo_full && !res_ok) begin
      overflow_d = 1'b1;
    end
    if (brq.res_valid && fifo_empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict_q       <= 1'b0;
      upd_valid_q        <= 1'b0;
      redirect_pc_q      <= '0;
      upd_addr_q         <= '0;
      upd_taken_q        <= 1'b0;
      overflow_q         <= 1'b0;
      underflow_q        <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      mispredict_q       <= mispredict_d;
      upd_valid_q        <= upd_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      upd_addr_q         <= upd_addr_d;
      upd_taken_q        <= upd_taken_d;
      overflow_q         <= overflow_d;
      underflow_q        <= underflow_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign brq.full             = fifo_full;
  assign brq.empty            = fifo_empty;
  assign brq.mispredict       = mispredict_q;
  assign brq.redirect_pc      = redirect_pc_q;
  assign brq.upd_valid        = upd_valid_q;
  assign brq.upd_addr         = upd_addr_q;
  assign brq.upd_taken        = upd_taken_q;
  assign brq.overflow         = overflow_q;
  assign brq.underflow        = underflow_q;
  assign brq.branch_count     = branch_count_q;
  assign brq.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench: a queue-based model predicts each cycle's outputs; a monitor compares them.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.CNT_W(CW)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .brq   (bus)
  );

  typedef struct {
    bit          rst;
    bit          upd;
    bit          mis;
    logic [31:0] addr;
    bit          taken;
    logic [31:0] redir;
    int          bc;
    int          mc;
    bit          ovf;
    bit          unf;
    bit          full;
    bit          empty;
  } exp_t;

  exp_t       sbq[$];
  brq_entry_t mq[$];
  bit         m_ovf, m_unf;
  int         m_bc, m_mc;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and predict the outputs that follow the next posedge.
  task automatic step(input bit r, input bit dv, input logic [31:0] pc, input logic [31:0] tgt,
                      input bit pred, input bit rv, input bit rt, input logic [31:0] rtgt);
    exp_t       e;
    brq_entry_t h;
    @(negedge clk);
    rst_n              = r;
    bus.dec_valid      = dv;
    bus.dec_pc         = pc;
    bus.dec_target     = tgt;
    bus.dec_prediction = pred;
    bus.res_valid      = rv;
    bus.res_taken      = rt;
    bus.res_target     = rtgt;
    e = '{default: 0};
    if (!r) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_bc = 0; m_mc = 0;
      e.rst = 1;
    end else begin
      if (rv && mq.size() == 0) m_unf = 1;
      if (rv && mq.size() > 0) begin
        h       = mq.pop_front();
        e.upd   = 1;
        e.addr  = h.pc;
        e.taken = rt;
        e.mis   = (h.prediction != rt) || (rt && h.target != rtgt);
        e.redir = rt ? rtgt : h.pc + 32'd4;
        if (m_bc < CMAX) m_bc++;
        if (e.mis && m_mc < CMAX) m_mc++;
      end
      if (e.mis) mq.delete();
      else if (dv) begin
        if (mq.size() < DEPTH) mq.push_back('{pc: pc, target: tgt, prediction: pred});
        else m_ovf = 1;
      end
    end
    e.bc = m_bc; e.mc = m_mc; e.ovf = m_ovf; e.unf = m_unf;
    e.full  = (mq.size() == DEPTH);
    e.empty = (mq.size() == 0);
    sbq.push_back(e);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_rst();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic enq(input logic [31:0] pc, input logic [31:0] tgt, input bit pred);
    step(1, 1, pc, tgt, pred, 0, 0, 0);
  endtask
  task automatic res(input bit rt, input logic [31:0] rtgt);
    step(1, 0, 0, 0, 0, 1, rt, rtgt);
  endtask

  // Monitor: one expectation per clock, compared 2 time units after the posedge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("upd_valid", 32'(bus.upd_valid), 32'(e.upd));
      chk("mispredict", 32'(bus.mispredict), 32'(e.mis));
      if (e.upd) begin
        chk("upd_addr", bus.upd_addr, e.addr);
        chk("upd_taken", 32'(bus.upd_taken), 32'(e.taken));
      end
      if (e.mis) chk("redirect_pc", bus.redirect_pc, e.redir);
      if (e.rst) begin
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_upd_addr", bus.upd_addr, 32'd0);
        chk("rst_upd_taken", 32'(bus.upd_taken), 32'd0);
      end
      chk("branch_count", 32'(bus.branch_count), 32'(e.bc));
      chk("mispredict_count", 32'(bus.mispredict_count), 32'(e.mc));
      chk("overflow", 32'(bus.overflow), 32'(e.ovf));
      chk("underflow", 32'(bus.underflow), 32'(e.unf));
      chk("full", 32'(bus.full), 32'(e.full));
      chk("empty", 32'(bus.empty), 32'(e.empty));
    end else if (bus.upd_valid === 1'b1 || bus.mispredict === 1'b1) begin
      chk("unexpected_output", 32'(bus.upd_valid), 32'd0);
    end
  end

  initial begin
    logic [31:0] pc, tg, rtg;
    rst_n = 1'b0;
    bus.dec_valid = 0; bus.dec_pc = 0; bus.dec_target = 0; bus.dec_prediction = 0;
    bus.res_valid = 0; bus.res_taken = 0; bus.res_target = 0;
    do_rst(); do_rst(); idle();

    // correct taken prediction
    enq(32'h100, 32'h140, 1); res(1, 32'h140); idle();
    // predicted not-taken, actually taken
    enq(32'h200, 32'h260, 0); res(1, 32'h260); idle();
    // predicted taken, actually not-taken
    enq(32'h300, 32'h340, 1); res(0, 32'h0); idle();
    // taken with wrong target
    enq(32'h380, 32'h3c0, 1); res(1, 32'h3c4); idle();

    // fill, overflow, drain, then one resolve too many
    for (int i = 0; i < 5; i++) enq(32'h400 + 32'(i * 16), 32'h440 + 32'(i * 16), 1);
    for (int i = 0; i < 5; i++) res(1, 32'h440 + 32'(i * 16));
    idle();

    // full with simultaneous enqueue and correct resolve
    do_rst();
    for (int i = 0; i < 4; i++) enq(32'h500 + 32'(i * 8), 32'h600, 1);
    step(1, 1, 32'h580, 32'h600, 1, 1, 1, 32'h600);
    for (int i = 0; i < 4; i++) res(1, 32'h600);
    idle();

    // mispredict head with wrong-path enqueue in same cycle
    for (int i = 0; i < 3; i++) enq(32'h700 + 32'(i * 4), 32'h780, 0);
    step(1, 1, 32'h7f0, 32'h7f8, 1, 1, 1, 32'h780);
    res(0, 32'h0); idle();

    // fall-through wraps at 2^32
    enq(32'hffff_fffc, 32'h10, 1); res(0, 32'h0); idle();

    // underflow with same-cycle enqueue, then reset mid-operation
    step(1, 1, 32'h800, 32'h840, 1, 1, 1, 32'h840);
    res(1, 32'h840);
    enq(32'h900, 32'h940, 1); enq(32'h904, 32'h944, 1);
    do_rst(); idle();

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      pc  = $urandom() & 32'hffff_fffc;
      tg  = pc + 32'($urandom_range(1, 4) * 16);
      rtg = $urandom() & 32'hffff_fffc;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) rtg = mq[0].target;
      step(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1, pc, tg,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, rtg);
    end
    idle(); idle();
    @(negedge clk);
    chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, which is the number of in-flight predictions tracked; it SHALL be a power of two and at least 2.
REQ-002 SHALL have parameter CNT_W, default 16, which is the width of the statistics counters.
REQ-003 Ports SHALL be exactly as listed below, clock and reset first:
  clk  in  1  sole clock; all state updates on posedge.
  rst_n  in  1  reset, synchronous, active-low.
  dec_valid  in  1  a branch was predicted at decode this cycle.
  dec_pc  in  32  PC of the predicted branch.
  dec_target  in  32  predicted target (pc+offset).
  dec_prediction  in  1  predicted direction (1 = taken).
  res_valid  in  1  the oldest in-flight branch was resolved this cycle.
  res_taken  in  1  actual direction.
  res_target  in  32  actual computed target.
  full  out  1  queue holds DEPTH entries.
  empty  out  1  queue holds 0 entries.
  mispredict  out  1  one-cycle pulse: the resolved branch was mispredicted.
  redirect_pc  out  32  correct fetch PC; valid while mispredict=1.
  upd_valid  out  1  one-cycle strobe to the predictor update port.
  upd_addr  out  32  PC of the resolved branch.
  upd_taken  out  1  actual direction of the resolved branch.
  overflow  out  1  sticky: an enqueue was attempted while full.
  underflow  out  1  sticky: a resolve arrived while the queue was empty.
  branch_count  out  CNT_W  saturating count of resolved branches.
  mispredict_count  out  CNT_W  saturating count of mispredicts.

Function
REQ-004 The queue SHALL be a circular FIFO of DEPTH entries {pc, target, prediction}, with head/tail pointers that wrap modulo DEPTH and an occupancy count from 0 to DEPTH.
REQ-005 dec_valid=1 with full=0 SHALL enqueue at the tail on that posedge; dec_valid=1 with full=1 SHALL drop the entry, set overflow, and leave the queue unchanged.
REQ-006 res_valid=1 with empty=0 SHALL pop the head entry and compare it against res_taken/res_target in the same cycle.
REQ-007 A mispredict SHALL occur when prediction!=res_taken, or when res_taken=1 and the entry target!=res_target.
REQ-008 mispredict, redirect_pc, upd_valid, upd_addr and upd_taken SHALL be registered and asserted exactly 1 cycle after the res_valid cycle, for 1 cycle only.
REQ-009 redirect_pc SHALL be res_target when res_taken=1, and entry pc+4 otherwise, using 32-bit wrap-around addition.
REQ-010 On a mispredict, all remaining entries SHALL be flushed (count becomes 0, tail equals head) on the resolving posedge; an enqueue in that same cycle SHALL be discarded because it is wrong-path.
REQ-011 A simultaneous enqueue and non-mispredicting resolve SHALL keep count unchanged; this SHALL be legal even when full=1, and the enqueue SHALL succeed because the pop frees a slot.
REQ-012 res_valid=1 with empty=1 SHALL set underflow and produce no upd_valid or mispredict; a same-cycle enqueue SHALL still proceed.
REQ-013 branch_count SHALL increment on each valid resolve and mispredict_count on each mispredict; both SHALL saturate at all-ones.
REQ-014 full and empty SHALL be derived combinationally from the registered count.

Reset
REQ-015 When rst_n=0 at a posedge, the block SHALL clear count, pointers, overflow, underflow, both counters, mispredict and upd_valid, and set redirect_pc, upd_addr and upd_taken to 0; empty SHALL then read 1.
REQ-016 Reset SHALL take priority over all simultaneous enqueues and resolves, and reset mid-operation SHALL discard all in-flight entries.
REQ-017 Entry storage need not be reset.

Structure
REQ-018 The default depth, address width (32) and counter width SHALL reside in the shared branch-prediction constants package or header, alongside the predictor's table sizes.
REQ-019 The FIFO storage and pointers SHALL be one sub-module, bp_fifo, which SHALL have push, pop and flush inputs and full, empty and head-data outputs.

Verification
REQ-020 After reset, enqueue pc=0x100, target=0x140, pred=1, then resolve taken=1, target=0x140 -> 1 cycle later upd_valid=1, upd_addr=0x100, upd_taken=1, mispredict=0, branch_count=1.
REQ-021 Enqueue pc=0x200, pred=0, then resolve taken=1, target=0x260 -> mispredict=1, redirect_pc=0x260, mispredict_count=1.
REQ-022 Enqueue pc=0x300, pred=1, target=0x340, then resolve taken=0 -> mispredict=1, redirect_pc=0x304.
REQ-023 Enqueue 4 entries, then a 5th -> full=1, overflow=1, and exactly 4 resolves follow before empty=1.
REQ-024 With 3 entries, mispredict the head while dec_valid=1 -> next cycle empty=1, and the discarded enqueue never resolves.
REQ-025 Resolve while empty -> underflow=1 and no upd_valid; assert rst_n=0 with 2 entries -> empty=1 and all flags 0.
